// File: rtl/task_admit_arbiter.sv
// task_admit_arbiter: vPIFO front-end scheduler.
// Admits one push/pop task per cycle into round-robin TaskFIFO lanes.
//
// Ports:
//   i_clk, i_arst_n     clock, async active-low reset
//   i_push, i_pop       per-tree requests, held until o_ready
//   i_push_data         per-tree payload+metadata
//   o_ready             one-hot (or zero) combinational grant
//   o_TaskFIFO_push     registered per-lane write strobe
//   o_TaskFIFO_data     registered per-lane task word
//   i_TaskFIFO_full     per-lane full flag
//   o_tree_count        per-tree occupancy
//   o_pop_drop(_tree)   pulse + tree id for a pop on an empty tree
module task_admit_arbiter #(
   parameter int PTW      = 16,
   parameter int MTW      = 16,
   parameter int LEVEL    = 4,
   parameter int TREE_NUM = 4,
   parameter int TREE_CAP = 1024,
   localparam int TNB     = $clog2(TREE_NUM),
   localparam int CNTW    = $clog2(TREE_CAP + 1),
   localparam int TDW     = PTW + MTW + 2 * TNB + 2
) (
   input  logic                i_clk,
   input  logic                i_arst_n,
   input  logic [TREE_NUM-1:0] i_push,
   input  logic [TREE_NUM-1:0] i_pop,
   input  logic [PTW+MTW-1:0]  i_push_data [0:TREE_NUM-1],
   output logic [TREE_NUM-1:0] o_ready,
   output logic [LEVEL-1:0]    o_TaskFIFO_push,
   output logic [TDW-1:0]      o_TaskFIFO_data [0:LEVEL-1],
   input  logic [LEVEL-1:0]    i_TaskFIFO_full,
   output logic [CNTW-1:0]     o_tree_count [0:TREE_NUM-1],
   output logic                o_pop_drop,
   output logic [TNB-1:0]      o_pop_drop_tree
);

   localparam int DW = PTW + MTW;
   localparam int LW = (LEVEL > 1) ? $clog2(LEVEL) : 1;

   logic [TREE_NUM-1:0] tree_elig;
   logic [LEVEL-1:0]    lane_elig;
   logic [TNB-1:0]      tree_ptr, win, tcand, tree_nxt;
   logic [LW-1:0]       lane_ptr, lane, lcand, lane_nxt;
   logic                win_vld, lane_vld, grant;
   logic                push_b, pop_ok, pop_bad, wr;
   logic [TDW-1:0]      word;
   int                  tsum, lsum;

   // A push into a full tree stalls the whole request, pop included.
   for (genvar t = 0; t < TREE_NUM; t++) begin : g_elig
      assign tree_elig[t] = (i_push[t] | i_pop[t]) &
                            ~(i_push[t] &
                              (o_tree_count[t] == CNTW'(TREE_CAP)));
   end

   // A lane just written is skipped so its full flag can catch up.
   assign lane_elig = ~i_TaskFIFO_full & ~o_TaskFIFO_push;

   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      tsum    = 0;
      tcand   = '0;
      for (int i = 0; i < TREE_NUM; i++) begin
         tsum = int'(tree_ptr) + i;
         if (tsum >= TREE_NUM) tsum = tsum - TREE_NUM;
         tcand = TNB'(tsum);
         if (!win_vld && tree_elig[tcand]) begin
            win     = tcand;
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      lane     = '0;
      lane_vld = 1'b0;
      lsum     = 0;
      lcand    = '0;
      for (int i = 0; i < LEVEL; i++) begin
         lsum = int'(lane_ptr) + i;
         if (lsum >= LEVEL) lsum = lsum - LEVEL;
         lcand = LW'(lsum);
         if (!lane_vld && lane_elig[lcand]) begin
            lane     = lcand;
            lane_vld = 1'b1;
         end
      end
   end

   assign grant    = win_vld & lane_vld;
   assign push_b   = i_push[win];
   assign pop_ok   = i_pop[win] & (o_tree_count[win] != '0);
   assign pop_bad  = i_pop[win] & (o_tree_count[win] == '0);
   assign wr       = push_b | pop_ok;
   assign tree_nxt = (win == TNB'(TREE_NUM - 1)) ? '0 : win + 1'b1;
   assign lane_nxt = (lane == LW'(LEVEL - 1)) ? '0 : lane + 1'b1;

   assign word = {push_b, pop_ok,
                  push_b ? win : {TNB{1'b0}},
                  pop_ok ? win : {TNB{1'b0}},
                  push_b ? i_push_data[win] : {DW{1'b0}}};

   always_comb begin
      o_ready = '0;
      if (grant && i_arst_n) o_ready[win] = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         tree_ptr        <= '0;
         lane_ptr        <= '0;
         o_TaskFIFO_push <= '0;
         o_pop_drop      <= 1'b0;
         o_pop_drop_tree <= '0;
         for (int l = 0; l < LEVEL; l++) o_TaskFIFO_data[l] <= '0;
         for (int t = 0; t < TREE_NUM; t++) o_tree_count[t] <= '0;
      end else begin
         o_TaskFIFO_push <= '0;
         o_pop_drop      <= 1'b0;
         if (grant) begin
            tree_ptr <= tree_nxt;
            if (pop_bad) begin
               o_pop_drop      <= 1'b1;
               o_pop_drop_tree <= win;
            end
            // Push and valid pop together leave occupancy unchanged.
            if (push_b && !pop_ok)
               o_tree_count[win] <= o_tree_count[win] + CNTW'(1);
            else if (!push_b && pop_ok)
               o_tree_count[win] <= o_tree_count[win] - CNTW'(1);
            if (wr) begin
               lane_ptr              <= lane_nxt;
               o_TaskFIFO_push[lane] <= 1'b1;
               o_TaskFIFO_data[lane] <= word;
            end
         end
      end
   end

endmodule

// File: tb/tb_task_admit_arbiter.sv
// tb_task_admit_arbiter: scenario tasks plus a scoreboard monitor
// for task_admit_arbiter with default parameters.
module tb_task_admit_arbiter;

   localparam int CAP = 1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  push, pop, ready, fifo_push, fifo_full;
   logic [31:0] push_data [0:3];
   logic [37:0] fifo_data [0:3];
   logic [10:0] tree_count [0:3];
   logic        pop_drop;
   logic [1:0]  drop_tree;

   int n_chk = 0;
   int n_pass = 0;

   task_admit_arbiter #(
      .PTW(16), .MTW(16), .LEVEL(4), .TREE_NUM(4), .TREE_CAP(CAP)
   ) dut (
      .i_clk           (clk),
      .i_arst_n        (rst_n),
      .i_push          (push),
      .i_pop           (pop),
      .i_push_data     (push_data),
      .o_ready         (ready),
      .o_TaskFIFO_push (fifo_push),
      .o_TaskFIFO_data (fifo_data),
      .i_TaskFIFO_full (fifo_full),
      .o_tree_count    (tree_count),
      .o_pop_drop      (pop_drop),
      .o_pop_drop_tree (drop_tree)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [3:0]  mask;
      int          lane;
      logic [37:0] word;
      bit          drop;
      logic [1:0]  dtree;
   } sb_t;

   sb_t sb [$];
   int  m_cnt [4];
   int  m_tptr, m_lptr;
   int  mcyc = 0;

   always @(negedge clk) begin : monitor
      sb_t        e, n;
      logic [3:0] er;
      int         w, l, mt;
      bit         wf, lf, pb, pv, pd;
      if (!rst_n) begin
         sb.delete();
         m_tptr = 0;
         m_lptr = 0;
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
         n_chk++;
         if (ready !== 4'b0000)
            $display("FAIL rst_ready: got %b want 0000", ready);
         else n_pass++;
         n_chk++;
         if (fifo_push !== 4'b0000)
            $display("FAIL rst_strobe: got %b want 0000", fifo_push);
         else n_pass++;
      end else begin
         mcyc++;
         e.due = 0; e.mask = '0; e.lane = 0;
         e.word = '0; e.drop = 0; e.dtree = '0;
         if (sb.size() > 0 && sb[0].due == mcyc) e = sb.pop_front();
         n_chk++;
         if (fifo_push !== e.mask)
            $display("FAIL sb_strobe: got %b want %b", fifo_push, e.mask);
         else n_pass++;
         if (e.mask != 0) begin
            n_chk++;
            if (fifo_data[e.lane] !== e.word)
               $display("FAIL sb_word lane %0d: got %h want %h",
                        e.lane, fifo_data[e.lane], e.word);
            else n_pass++;
         end
         n_chk++;
         if (pop_drop !== e.drop)
            $display("FAIL sb_drop: got %b want %b", pop_drop, e.drop);
         else n_pass++;
         if (e.drop) begin
            n_chk++;
            if (drop_tree !== e.dtree)
               $display("FAIL sb_drop_tree: got %0d want %0d",
                        drop_tree, e.dtree);
            else n_pass++;
         end
         wf = 0; lf = 0; w = 0; l = 0;
         for (int i = 0; i < 4; i++) begin
            mt = (m_tptr + i) % 4;
            if (!wf && (push[mt] || pop[mt]) &&
                !(push[mt] && m_cnt[mt] == CAP)) begin
               w = mt; wf = 1;
            end
         end
         for (int i = 0; i < 4; i++) begin
            mt = (m_lptr + i) % 4;
            if (!lf && !fifo_full[mt] && !e.mask[mt]) begin
               l = mt; lf = 1;
            end
         end
         er = 4'b0000;
         if (wf && lf) begin
            er[w]  = 1'b1;
            m_tptr = (w + 1) % 4;
            pb = push[w];
            pv = pop[w] && m_cnt[w] != 0;
            pd = pop[w] && m_cnt[w] == 0;
            n.due = mcyc + 1; n.mask = '0; n.lane = l; n.word = '0;
            n.drop = pd; n.dtree = 2'(w);
            if (pb || pv) begin
               n.mask = 4'(1 << l);
               n.word = {pb, pv, pb ? 2'(w) : 2'd0, pv ? 2'(w) : 2'd0,
                         pb ? push_data[w] : 32'd0};
               m_lptr = (l + 1) % 4;
            end
            if (pb && !pv) m_cnt[w]++;
            else if (!pb && pv) m_cnt[w]--;
            if (pb || pv || pd) sb.push_back(n);
         end
         n_chk++;
         if (ready !== er)
            $display("FAIL sb_ready: got %b want %b", ready, er);
         else n_pass++;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic samp();
      @(negedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      push = '0; pop = '0; fifo_full = '0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      push = 4'b1111;
      samp();
      n_chk++;
      if (ready !== 4'b0000)
         $display("FAIL reset_ready: got %b want 0000", ready);
      else n_pass++;
      n_chk++;
      if (pop_drop !== 1'b0 || drop_tree !== 2'd0)
         $display("FAIL reset_drop: got %b/%0d want 0/0", pop_drop, drop_tree);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if (tree_count[i] !== 11'd0 || fifo_data[i] !== 38'd0)
            $display("FAIL reset_state %0d: got cnt %0d data %h want 0",
                     i, tree_count[i], fifo_data[i]);
         else n_pass++;
      end
      tick();
      push  = '0;
      rst_n = 1'b1;
   endtask

   task automatic test_single_push();
      push_data[2] = 32'h1234_5678;
      push = 4'b0100;
      samp();
      n_chk++;
      if (ready !== 4'b0100)
         $display("FAIL single_ready: got %b want 0100", ready);
      else n_pass++;
      tick();
      push = '0;
      samp();
      n_chk++;
      if (fifo_push !== 4'b0001)
         $display("FAIL single_strobe: got %b want 0001", fifo_push);
      else n_pass++;
      n_chk++;
      if (fifo_data[0] !== {1'b1, 1'b0, 2'd2, 2'd0, 32'h1234_5678})
         $display("FAIL single_word: got %h want %h", fifo_data[0],
                  {1'b1, 1'b0, 2'd2, 2'd0, 32'h1234_5678});
      else n_pass++;
      n_chk++;
      if (tree_count[2] !== 11'd1)
         $display("FAIL single_count: got %0d want 1", tree_count[2]);
      else n_pass++;
      tick();
   endtask

   task automatic test_round_robin();
      int exp_t [6] = '{0, 1, 3, 0, 1, 3};
      do_reset();
      for (int t = 0; t < 4; t++) push_data[t] = 32'hA000_0000 | t;
      push = 4'b1011;
      for (int i = 0; i < 6; i++) begin
         samp();
         n_chk++;
         if (ready !== 4'(1 << exp_t[i]))
            $display("FAIL rr_ready %0d: got %b want %b",
                     i, ready, 4'(1 << exp_t[i]));
         else n_pass++;
         if (i > 0) begin
            n_chk++;
            if (fifo_push !== 4'(1 << ((i - 1) % 4)))
               $display("FAIL rr_lane %0d: got %b want %b",
                        i, fifo_push, 4'(1 << ((i - 1) % 4)));
            else n_pass++;
         end
         tick();
      end
      push = '0;
      samp();
      n_chk++;
      if (fifo_push !== 4'b0010)
         $display("FAIL rr_lane_last: got %b want 0010", fifo_push);
      else n_pass++;
      n_chk++;
      if (tree_count[0] !== 11'd2 || tree_count[1] !== 11'd2 ||
          tree_count[3] !== 11'd2)
         $display("FAIL rr_counts: got %0d %0d %0d want 2 2 2",
                  tree_count[0], tree_count[1], tree_count[3]);
      else n_pass++;
      tick();
   endtask

   task automatic test_pop_drop();
      do_reset();
      pop = 4'b0010;
      samp();
      n_chk++;
      if (ready !== 4'b0010)
         $display("FAIL drop_ready: got %b want 0010", ready);
      else n_pass++;
      tick();
      pop = '0;
      samp();
      n_chk++;
      if (pop_drop !== 1'b1 || drop_tree !== 2'd1)
         $display("FAIL drop_pulse: got %b/%0d want 1/1", pop_drop, drop_tree);
      else n_pass++;
      n_chk++;
      if (fifo_push !== 4'b0000 || tree_count[1] !== 11'd0)
         $display("FAIL drop_nowrite: got %b cnt %0d want 0000 cnt 0",
                  fifo_push, tree_count[1]);
      else n_pass++;
      tick();
   endtask

   task automatic test_tree_full();
      do_reset();
      push_data[0] = 32'h0000_F00D;
      push_data[1] = 32'h1111_2222;
      push = 4'b0001;
      repeat (CAP) tick();
      n_chk++;
      if (tree_count[0] !== 11'(CAP))
         $display("FAIL full_count: got %0d want %0d", tree_count[0], CAP);
      else n_pass++;
      push = 4'b0011;
      samp();
      n_chk++;
      if (ready !== 4'b0010)
         $display("FAIL full_other: got %b want 0010", ready);
      else n_pass++;
      tick();
      push = 4'b0001;
      pop  = 4'b0001;
      samp();
      n_chk++;
      if (ready !== 4'b0000)
         $display("FAIL full_pushpop: got %b want 0000", ready);
      else n_pass++;
      tick();
      push = 4'b0000;
      samp();
      n_chk++;
      if (ready !== 4'b0001)
         $display("FAIL full_poponly: got %b want 0001", ready);
      else n_pass++;
      tick();
      pop = '0;
      n_chk++;
      if (tree_count[0] !== 11'(CAP - 1) || tree_count[1] !== 11'd1)
         $display("FAIL full_after: got %0d %0d want %0d 1",
                  tree_count[0], tree_count[1], CAP - 1);
      else n_pass++;
      tick();
   endtask

   task automatic test_push_pop();
      do_reset();
      push_data[3] = 32'h1111_0000;
      push = 4'b1000;
      repeat (5) tick();
      push = '0;
      n_chk++;
      if (tree_count[3] !== 11'd5)
         $display("FAIL pp_prefill: got %0d want 5", tree_count[3]);
      else n_pass++;
      push_data[3] = 32'hCAFE_F00D;
      push = 4'b1000;
      pop  = 4'b1000;
      samp();
      n_chk++;
      if (ready !== 4'b1000)
         $display("FAIL pp_ready: got %b want 1000", ready);
      else n_pass++;
      tick();
      push = '0;
      pop  = '0;
      samp();
      n_chk++;
      if (fifo_push !== 4'b0010 ||
          fifo_data[1] !== {1'b1, 1'b1, 2'd3, 2'd3, 32'hCAFE_F00D})
         $display("FAIL pp_word: got %b %h want 0010 %h", fifo_push,
                  fifo_data[1], {1'b1, 1'b1, 2'd3, 2'd3, 32'hCAFE_F00D});
      else n_pass++;
      n_chk++;
      if (tree_count[3] !== 11'd5)
         $display("FAIL pp_count: got %0d want 5", tree_count[3]);
      else n_pass++;
      tick();
      do_reset();
      push_data[3] = 32'h0BAD_BEEF;
      push = 4'b1000;
      pop  = 4'b1000;
      samp();
      tick();
      push = '0;
      pop  = '0;
      samp();
      n_chk++;
      if (fifo_push !== 4'b0001 ||
          fifo_data[0] !== {1'b1, 1'b0, 2'd3, 2'd0, 32'h0BAD_BEEF})
         $display("FAIL pp0_word: got %b %h want 0001 %h", fifo_push,
                  fifo_data[0], {1'b1, 1'b0, 2'd3, 2'd0, 32'h0BAD_BEEF});
      else n_pass++;
      n_chk++;
      if (pop_drop !== 1'b1 || drop_tree !== 2'd3 || tree_count[3] !== 11'd1)
         $display("FAIL pp0_drop: got %b/%0d cnt %0d want 1/3 cnt 1",
                  pop_drop, drop_tree, tree_count[3]);
      else n_pass++;
      tick();
   endtask

   task automatic test_all_full();
      do_reset();
      push_data[0] = 32'h5555_AAAA;
      push_data[2] = 32'h7777_8888;
      fifo_full = 4'b1111;
      push = 4'b0101;
      for (int i = 0; i < 10; i++) begin
         samp();
         n_chk++;
         if (ready !== 4'b0000)
            $display("FAIL allfull_ready %0d: got %b want 0000", i, ready);
         else n_pass++;
         tick();
      end
      fifo_full = 4'b1011;
      samp();
      n_chk++;
      if (ready !== 4'b0001)
         $display("FAIL release_ready: got %b want 0001", ready);
      else n_pass++;
      tick();
      push = 4'b0100;
      n_chk++;
      if (fifo_push !== 4'b0100)
         $display("FAIL release_lane: got %b want 0100", fifo_push);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (fifo_push !== 4'b0000 || tree_count[0] !== 11'd0)
         $display("FAIL midwrite_reset: got %b cnt %0d want 0000 cnt 0",
                  fifo_push, tree_count[0]);
      else n_pass++;
      push = '0;
      fifo_full = '0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      push = '0;
      pop = '0;
      fifo_full = '0;
      for (int i = 0; i < 4; i++) push_data[i] = '0;
      test_reset();
      test_single_push();
      test_round_robin();
      test_pop_drop();
      test_tree_full();
      test_push_pop();
      test_all_full();
      samp();
      n_chk++;
      if (sb.size() !== 0)
         $display("FAIL sb_leftover: got %0d want 0", sb.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
